uart_cmd_tx: RTL and testbench

- Command-frame UART transmitter: the host-side end of the serial command link into the trigger/vector controller.
- Accepts one command (opcode byte plus 0-4 payload bytes) through a start/busy handshake.
- Serialises the command as back-to-back 8N1 characters on a single tx line, LSB first, at a fixed baud derived from the 12 MHz system clock.
- Drives the controller's rx pin in loopback benches and in host-emulation builds.

---
 rtl/uart_cmd_tx.sv | 148 ++++++++++++++
 tb/tb_uart_cmd_tx.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_tx.sv
// ----------------------------------------------------------------------------
// uart_cmd_tx : command-frame 8N1 UART transmitter (opcode + 0..4 payload bytes)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_cmd_tx #(
   parameter int CLKS_PER_BIT = 1250,
   parameter int IDLE_BITS    = 0,
   parameter int MAX_BYTES    = 4
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        start,
   input  logic [7:0]  opcode,
   input  logic [31:0] payload,
   input  logic [2:0]  nbytes,
   output logic        tx,
   output logic        busy,
   output logic        byte_done,
   output logic        done
);

   localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int GAP_W = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;
   localparam int CNT_W = (GAP_W > 3) ? GAP_W : 3;

   localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(7);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);
   localparam logic [2:0]       MAX_N     = 3'(MAX_BYTES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t             state, state_n;
   logic [TMR_W-1:0]   timer, timer_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [7:0]         shreg, shreg_n;
   logic [31:0]        pend, pend_n;
   logic [2:0]         remaining, remaining_n;
   logic               bit_end;

   assign bit_end = (timer == BIT_LAST);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state     <= S_IDLE;
         timer     <= '0;
         cnt       <= '0;
         shreg     <= '0;
         pend      <= '0;
         remaining <= '0;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         cnt       <= cnt_n;
         shreg     <= shreg_n;
         pend      <= pend_n;
         remaining <= remaining_n;
      end
   end

   always_comb begin
      state_n     = state;
      timer_n     = bit_end ? '0 : timer + 1'b1;
      cnt_n       = cnt;
      shreg_n     = shreg;
      pend_n      = pend;
      remaining_n = remaining;

      case (state)
         S_IDLE: begin
            timer_n = '0;
            cnt_n   = '0;
            if (start) begin
               state_n     = S_START;
               shreg_n     = opcode;
               pend_n      = payload;
               remaining_n = (nbytes > MAX_N) ? MAX_N : nbytes;
            end
         end

         S_START: begin
            if (bit_end) begin
               state_n = S_DATA;
               cnt_n   = '0;
            end
         end

         S_DATA: begin
            if (bit_end) begin
               shreg_n = shreg >> 1;
               if (cnt == DATA_LAST) begin
                  state_n = S_STOP;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end

         S_STOP: begin
            if (bit_end) begin
               cnt_n = '0;
               if (remaining == 3'd0) begin
                  state_n = S_IDLE;
               end else begin
                  // Next payload byte is pulled from the low end of the latched word.
                  shreg_n     = pend[7:0];
                  pend_n      = pend >> 8;
                  remaining_n = remaining - 1'b1;
                  state_n     = (IDLE_BITS > 0) ? S_GAP : S_START;
               end
            end
         end

         S_GAP: begin
            if (bit_end) begin
               if (cnt == GAP_LAST) begin
                  state_n = S_START;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   assign tx        = (state == S_START) ? 1'b0 :
                      (state == S_DATA)  ? shreg[0] : 1'b1;
   assign busy      = (state != S_IDLE);
   assign byte_done = (state == S_STOP) && bit_end;
   assign done      = byte_done && (remaining == 3'd0);

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_tx : self-checking bench, two DUTs (no gap / 2-bit gap) vs waveform model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_cmd_tx;

   localparam int C   = 8;
   localparam int IB1 = 2;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  opcode = 8'h00;
   logic [31:0] payload = 32'h0;
   logic [2:0]  nbytes = 3'd0;
   logic        tx0, busy0, bd0, done0;
   logic        tx1, busy1, bd1, done1;

   always #5 clk = ~clk;

   uart_cmd_tx #(.CLKS_PER_BIT(C), .IDLE_BITS(0), .MAX_BYTES(4)) dut0 (
      .clk(clk), .nrst(nrst), .start(start), .opcode(opcode), .payload(payload),
      .nbytes(nbytes), .tx(tx0), .busy(busy0), .byte_done(bd0), .done(done0)
   );

   uart_cmd_tx #(.CLKS_PER_BIT(C), .IDLE_BITS(IB1), .MAX_BYTES(4)) dut1 (
      .clk(clk), .nrst(nrst), .start(start), .opcode(opcode), .payload(payload),
      .nbytes(nbytes), .tx(tx1), .busy(busy1), .byte_done(bd1), .done(done1)
   );

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int done0_cnt = 0;
   bit chk_en = 1'b0;

   logic [7:0] dec_b    [2][5];
   int         dec_fall [2][5];
   int         len_g    [2];

   // Expected per-cycle {tx, byte_done, done}; a non-empty queue means busy.
   logic [2:0] q0[$];
   logic [2:0] q1[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic timeout_fail(input string nm, input int waited);
      total++;
      $display("FAIL %s: no event after %0d cycles (cycle %0d)", nm, waited, cyc);
   endtask

   task automatic push_frame(input int sel, input logic [7:0] op, input logic [31:0] pl,
                             input logic [2:0] nb);
      int n;
      int idle;
      logic [7:0] b;
      logic [9:0] ch;
      logic [2:0] e;
      n    = (nb > 3'd4) ? 4 : int'(nb);
      idle = (sel != 0) ? IB1 : 0;
      for (int k = 0; k <= n; k++) begin
         b  = (k == 0) ? op : pl[8*(k-1) +: 8];
         ch = {1'b1, b, 1'b0};
         for (int i = 0; i < 10; i++) begin
            for (int t = 0; t < C; t++) begin
               e[2] = ch[i];
               e[1] = (i == 9) && (t == C-1);
               e[0] = e[1] && (k == n);
               if (sel != 0) q1.push_back(e); else q0.push_back(e);
            end
         end
         if (k < n) begin
            for (int t = 0; t < idle*C; t++) begin
               if (sel != 0) q1.push_back(3'b100); else q0.push_back(3'b100);
            end
         end
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!nrst) begin
         q0.delete();
         q1.delete();
      end else begin
         if (q0.size() > 0) void'(q0.pop_front());
         else if (start) push_frame(0, opcode, payload, nbytes);
         if (q1.size() > 0) void'(q1.pop_front());
         else if (start) push_frame(1, opcode, payload, nbytes);
      end
   end

   always @(negedge clk) begin
      logic [2:0] e0, e1;
      if (done0) done0_cnt++;
      if (chk_en) begin
         e0 = (q0.size() > 0) ? q0[0] : 3'b100;
         e1 = (q1.size() > 0) ? q1[0] : 3'b100;
         chk("dut0.tx",        tx0,   e0[2]);
         chk("dut0.byte_done", bd0,   e0[1]);
         chk("dut0.done",      done0, e0[0]);
         chk("dut0.busy",      busy0, q0.size() > 0);
         chk("dut1.tx",        tx1,   e1[2]);
         chk("dut1.byte_done", bd1,   e1[1]);
         chk("dut1.done",      done1, e1[0]);
         chk("dut1.busy",      busy1, q1.size() > 0);
      end
   end

   function automatic logic txs(input int sel);
      return (sel != 0) ? tx1 : tx0;
   endfunction

   function automatic logic bsy(input int sel);
      return (sel != 0) ? busy1 : busy0;
   endfunction

   task automatic send(input logic [7:0] op, input logic [31:0] pl, input logic [2:0] nb);
      opcode  = op;
      payload = pl;
      nbytes  = nb;
      start   = 1'b1;
      @(posedge clk); #2;
      start   = 1'b0;
      opcode  = ~op;
      payload = ~pl;
      nbytes  = 3'd0;
   endtask

   task automatic decode(input int sel, input int nchars);
      logic [7:0] b;
      int w;
      for (int c = 0; c < nchars; c++) begin
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (txs(sel) !== 1'b0 && w < 3000);
         if (txs(sel) !== 1'b0) begin
            timeout_fail("decode_start_bit", w);
            return;
         end
         dec_fall[sel][c] = cyc;
         repeat (C/2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (C) @(negedge clk);
            b[i] = txs(sel);
         end
         repeat (C) @(negedge clk);
         chk("stop_bit", txs(sel), 1'b1);
         dec_b[sel][c] = b;
      end
   endtask

   task automatic measure_len(input int sel);
      int n;
      n = 0;
      @(negedge clk);
      while (bsy(sel) === 1'b1 && n < 5000) begin
         n++;
         @(negedge clk);
      end
      len_g[sel] = n;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while ((busy0 !== 1'b0 || busy1 !== 1'b0) && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (busy0 !== 1'b0 || busy1 !== 1'b0) timeout_fail("wait_idle", w);
      repeat (3) @(negedge clk);
      @(posedge clk); #2;
   endtask

   initial begin
      int lows;
      int dcnt;
      repeat (3) @(posedge clk);
      chk_en = 1'b1;
      repeat (17) @(posedge clk);
      @(negedge clk);
      chk("reset.tx",        tx0,   1'b1);
      chk("reset.busy",      busy0, 1'b0);
      chk("reset.byte_done", bd0,   1'b0);
      chk("reset.done",      done0, 1'b0);
      @(posedge clk); #2;
      nrst = 1'b1;
      repeat (3) @(posedge clk); #2;

      // Opcode-only frame
      send(8'h5C, 32'h0, 3'd0);
      fork
         decode(0, 1);
         measure_len(0);
         measure_len(1);
      join
      chk("op_only.byte", dec_b[0][0], 8'h5C);
      chk("op_only.len0", len_g[0], 80);
      chk("op_only.len1", len_g[1], 80);
      wait_idle();

      // Set command, three payload bytes
      send(8'h53, 32'h0003_0100, 3'd3);
      fork
         decode(0, 4);
         measure_len(0);
         measure_len(1);
      join
      chk("set.b0", dec_b[0][0], 8'h53);
      chk("set.b1", dec_b[0][1], 8'h00);
      chk("set.b2", dec_b[0][2], 8'h01);
      chk("set.b3", dec_b[0][3], 8'h03);
      chk("set.len0", len_g[0], 320);
      chk("set.len1", len_g[1], 368);
      wait_idle();

      // Gap insertion on the IDLE_BITS=2 instance
      send(8'h53, 32'h0000_0000, 3'd1);
      fork
         decode(0, 2);
         decode(1, 2);
         measure_len(1);
      join
      chk("gap.spacing0", dec_fall[0][1] - dec_fall[0][0], 80);
      chk("gap.spacing1", dec_fall[1][1] - dec_fall[1][0], 96);
      chk("gap.b1_0", dec_b[1][0], 8'h53);
      chk("gap.b1_1", dec_b[1][1], 8'h00);
      chk("gap.len1", len_g[1], 176);
      wait_idle();

      // Clamp nbytes=7 to 4, with a start pulse mid-frame that must be ignored
      send(8'h53, 32'h1502_0000, 3'd7);
      fork
         decode(0, 5);
         measure_len(0);
         begin
            repeat (200) @(posedge clk); #2;
            opcode = 8'hA5;
            start  = 1'b1;
            @(posedge clk); #2;
            start  = 1'b0;
         end
      join
      chk("clamp.b0", dec_b[0][0], 8'h53);
      chk("clamp.b1", dec_b[0][1], 8'h00);
      chk("clamp.b2", dec_b[0][2], 8'h00);
      chk("clamp.b3", dec_b[0][3], 8'h02);
      chk("clamp.b4", dec_b[0][4], 8'h15);
      chk("clamp.len0", len_g[0], 400);
      wait_idle();
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx0 !== 1'b1) lows++;
      end
      chk("clamp.no_extra_char", lows, 0);
      @(posedge clk); #2;

      // Reset during data bit 4 of the opcode
      send(8'h53, 32'h0, 3'd0);
      dcnt = done0_cnt;
      repeat (44) @(posedge clk); #2;
      nrst = 1'b0;
      @(posedge clk); #2;
      nrst = 1'b1;
      @(negedge clk);
      chk("midrst.tx",   tx0,   1'b1);
      chk("midrst.busy", busy0, 1'b0);
      repeat (100) @(negedge clk);
      chk("midrst.no_done", done0_cnt, dcnt);
      @(posedge clk); #2;
      send(8'h5C, 32'h0, 3'd0);
      fork
         decode(0, 1);
         measure_len(0);
      join
      chk("midrst.byte", dec_b[0][0], 8'h5C);
      chk("midrst.len0", len_g[0], 80);
      wait_idle();

      // Back-to-back frames with start held high
      opcode = 8'h11;
      nbytes = 3'd0;
      start  = 1'b1;
      @(posedge clk); #2;
      opcode = 8'h22;
      fork
         decode(0, 2);
         decode(1, 2);
      join
      start = 1'b0;
      chk("b2b.b0", dec_b[0][0], 8'h11);
      chk("b2b.b1", dec_b[0][1], 8'h22);
      chk("b2b.spacing0", dec_fall[0][1] - dec_fall[0][0], 81);
      chk("b2b.spacing1", dec_fall[1][1] - dec_fall[1][0], 81);
      wait_idle();

      // Randomized traffic, including starts while busy and occasional resets
      for (int it = 0; it < 40; it++) begin
         opcode  = 8'($urandom);
         payload = $urandom;
         nbytes  = 3'($urandom_range(0, 7));
         start   = 1'b1;
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #2;
         start   = 1'b0;
         opcode  = 8'($urandom);
         payload = $urandom;
         nbytes  = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(1, 300)) @(posedge clk);
            #2;
            nrst = 1'b0;
            @(posedge clk); #2;
            nrst = 1'b1;
         end
         repeat ($urandom_range(0, 450)) @(posedge clk);
         #2;
      end
      wait_idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
